// File: rtl/ram_mp_arb_pkg.sv
// ram_mp_arb_pkg: shared constants and helpers for the arbitrated multi-client RAM.
package ram_mp_arb_pkg;
    localparam int CDataLenDef = 128;
    localparam int CBeLen = CDataLenDef / 8;
    function automatic int fBeLen(input int dataLen);
        return dataLen / 8;
    endfunction
    function automatic int fIdxLen(input int cnt);
        return (cnt > 1) ? $clog2(cnt) : 1;
    endfunction
    // Even parity: stored bit makes the 9-bit group's population count even.
    function automatic logic fParity(input logic [7:0] b);
        return ^b;
    endfunction
endpackage

// File: rtl/ram_mp_rr_arb.sv
// ram_mp_rr_arb: round-robin grant over client requests with a rotating priority pointer.
module ram_mp_rr_arb
    import ram_mp_arb_pkg::*;
#(
    parameter int CChCnt = 4,
    localparam int CIdxLen = fIdxLen(CChCnt)
)(
    input  logic               AClkH,
    input  logic               AResetH,
    input  logic               AClkHEn,
    input  logic [CChCnt-1:0]  AReq,
    output logic [CChCnt-1:0]  AGnt,
    output logic [CIdxLen-1:0] AGntIdx,
    output logic               AGntVld
);
    logic [CIdxLen-1:0] rrPtr;
    logic [CIdxLen-1:0] idx;
    logic               hit;
    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int k = CChCnt - 1; k >= 0; k--) begin
            if (AReq[CIdxLen'((int'(rrPtr) + k) % CChCnt)]) begin
                idx = CIdxLen'((int'(rrPtr) + k) % CChCnt);
                hit = 1'b1;
            end
        end
    end
    assign AGntVld = hit & AClkHEn & ~AResetH;
    assign AGntIdx = idx;
    assign AGnt = AGntVld ? CChCnt'(1) << idx : '0;
    always_ff @(posedge AClkH or posedge AResetH)
        if (AResetH) rrPtr <= '0;
        else if (AGntVld) rrPtr <= CIdxLen'((int'(idx) + 1) % CChCnt);
endmodule

// File: rtl/ram_mp_arb.sv
// ram_mp_arb: single-port RAM shared by CChCnt clients via round-robin arbitration.
// Optional byte parity storage/check enabled by RAM_MP_ARB_PARITY_EN.
module ram_mp_arb
    import ram_mp_arb_pkg::*;
#(
    parameter int CChCnt   = 4,
    parameter int CAddrLen = 13,
    parameter int CDataLen = CDataLenDef,
    parameter int CMemSize = 2**CAddrLen,
    parameter int CRdPipe  = 0
)(
    input  logic                         AClkH,
    input  logic                         AResetH,
    input  logic                         AClkHEn,
    input  logic [CChCnt-1:0]            AReq,
    input  logic [CChCnt-1:0]            AWrEn,
    input  logic [CChCnt*CAddrLen-1:0]   AAddr,
    input  logic [CChCnt*CDataLen-1:0]   AMosi,
    input  logic [CChCnt*CDataLen/8-1:0] ABe,
    output logic [CChCnt-1:0]            AAck,
    output logic [CDataLen-1:0]          AMiso,
    output logic [CChCnt-1:0]            AMisoVld,
    output logic                         AParErr
);
    localparam int CBeCnt  = fBeLen(CDataLen);
    localparam int CIdxLen = fIdxLen(CChCnt);
    localparam int CMemAw  = fIdxLen(CMemSize);

    logic [CChCnt-1:0]   gnt;
    logic [CIdxLen-1:0]  gIdx;
    logic                gVld;
    logic                gWr;
    logic                gInRange;
    logic [CAddrLen-1:0] gAddr;
    logic [CMemAw-1:0]   memIdx;
    logic [CDataLen-1:0] gData;
    logic [CBeCnt-1:0]   gBe;

    ram_mp_rr_arb #(.CChCnt(CChCnt)) uArb (
        .AClkH   (AClkH),
        .AResetH (AResetH),
        .AClkHEn (AClkHEn),
        .AReq    (AReq),
        .AGnt    (gnt),
        .AGntIdx (gIdx),
        .AGntVld (gVld)
    );

    assign AAck     = gnt;
    assign gWr      = AWrEn[gIdx];
    assign gAddr    = AAddr[gIdx*CAddrLen +: CAddrLen];
    assign gData    = AMosi[gIdx*CDataLen +: CDataLen];
    assign gBe      = ABe[gIdx*CBeCnt +: CBeCnt];
    assign gInRange = 32'(gAddr) < 32'(CMemSize);
    assign memIdx   = CMemAw'(gAddr);

    logic [CDataLen-1:0] memData [CMemSize];
    logic [CDataLen-1:0] rdData;
    logic [CChCnt-1:0]   rdVld;
    logic                rdErr;

    always_ff @(posedge AClkH)
        if (gVld && gWr && gInRange)
            for (int b = 0; b < CBeCnt; b++)
                if (gBe[b]) memData[memIdx][b*8 +: 8] <= gData[b*8 +: 8];

    // Out-of-range reads still complete, returning zero.
    always_ff @(posedge AClkH)
        if (gVld && !gWr) rdData <= gInRange ? memData[memIdx] : '0;

    always_ff @(posedge AClkH or posedge AResetH)
        if (AResetH) rdVld <= '0;
        else if (AClkHEn) rdVld <= (gVld && !gWr) ? gnt : '0;

`ifdef RAM_MP_ARB_PARITY_EN
    logic [CBeCnt-1:0] memPar [CMemSize];
    logic [CBeCnt-1:0] rdPar;
    logic [CBeCnt-1:0] rdParCalc;
    always_ff @(posedge AClkH)
        if (gVld && gWr && gInRange)
            for (int b = 0; b < CBeCnt; b++)
                if (gBe[b]) memPar[memIdx][b] <= fParity(gData[b*8 +: 8]);
    always_ff @(posedge AClkH)
        if (gVld && !gWr) rdPar <= gInRange ? memPar[memIdx] : '0;
    always_comb
        for (int b = 0; b < CBeCnt; b++) rdParCalc[b] = fParity(rdData[b*8 +: 8]);
    assign rdErr = |(rdPar ^ rdParCalc);
`else
    assign rdErr = 1'b0;
`endif

    logic [CDataLen-1:0] outData;
    logic [CChCnt-1:0]   outVld;
    logic                outErr;

    if (CRdPipe == 1) begin : gPipe
        logic [CDataLen-1:0] pData;
        logic [CChCnt-1:0]   pVld;
        logic                pErr;
        always_ff @(posedge AClkH or posedge AResetH)
            if (AResetH) begin
                pVld <= '0;
                pErr <= 1'b0;
            end else if (AClkHEn) begin
                pVld <= rdVld;
                pErr <= rdErr;
            end
        always_ff @(posedge AClkH)
            if (AClkHEn) pData <= rdData;
        assign outData = pData;
        assign outVld  = pVld;
        assign outErr  = pErr;
    end else begin : gNoPipe
        assign outData = rdData;
        assign outVld  = rdVld;
        assign outErr  = rdErr;
    end

    assign AMisoVld = outVld & {CChCnt{AClkHEn}};
    assign AMiso    = (|AMisoVld) ? outData : '0;
    assign AParErr  = (|AMisoVld) & outErr;
endmodule

// File: tb/tb_ram_mp_arb.sv
// tb_ram_mp_arb: directed and randomized checks of ram_mp_arb against a behavioural model.
module tb_ram_mp_arb;
    localparam int NCh = 4, AW = 13, DW = 128, BW = 16, MS = 100, RP = 0;

    logic              AClkH = 1'b0;
    logic              AResetH, AClkHEn;
    logic [NCh-1:0]    AReq, AWrEn, AAck, AMisoVld;
    logic [NCh*AW-1:0] AAddr;
    logic [NCh*DW-1:0] AMosi;
    logic [NCh*BW-1:0] ABe;
    logic [DW-1:0]     AMiso;
    logic              AParErr;

    ram_mp_arb #(.CChCnt(NCh), .CAddrLen(AW), .CDataLen(DW), .CMemSize(MS), .CRdPipe(RP)) dut (
        .AClkH    (AClkH),
        .AResetH  (AResetH),
        .AClkHEn  (AClkHEn),
        .AReq     (AReq),
        .AWrEn    (AWrEn),
        .AAddr    (AAddr),
        .AMosi    (AMosi),
        .ABe      (ABe),
        .AAck     (AAck),
        .AMiso    (AMiso),
        .AMisoVld (AMisoVld),
        .AParErr  (AParErr)
    );

    always #5 AClkH = ~AClkH;

    typedef struct {
        logic [NCh-1:0] vld;
        logic [DW-1:0]  data;
        logic           err;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] mem [MS];
    bit            bad [MS];
    int            ptr = 0, checks = 0, failures = 0, n, a;
    logic [NCh-1:0] obsAck, obsVld;
    logic [DW-1:0]  obsMiso;
    logic           obsPar;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setCh(input int c, input logic w, input int ad, input logic [DW-1:0] d, input logic [BW-1:0] b);
        AWrEn[c] = w;
        AAddr[c*AW +: AW] = AW'(ad);
        AMosi[c*DW +: DW] = d;
        ABe[c*BW +: BW] = b;
    endtask

    // One clock: inputs are already driven; check mid-cycle, then advance the model at the edge.
    task automatic tick();
        int g, ad;
        ent_t e, x;
        logic [NCh-1:0] expAck;
        if (AResetH) begin
            q.delete();
            ptr = 0;
        end
        g = -1;
        for (int k = 0; k < NCh; k++)
            if (g < 0 && AReq[(ptr + k) % NCh]) g = (ptr + k) % NCh;
        if (AResetH || !AClkHEn) g = -1;
        expAck = (g < 0) ? '0 : NCh'(1) << g;
        x = '{vld: '0, data: '0, err: 1'b0};
        if (!AResetH && AClkHEn && q.size() == RP + 1) x = q[0];
        @(negedge AClkH);
        obsAck = AAck;
        obsVld = AMisoVld;
        obsMiso = AMiso;
        obsPar = AParErr;
        chk("ack", AAck, expAck);
        chk("miso_vld", AMisoVld, x.vld);
        chk("miso", AMiso, (x.vld != 0) ? x.data : '0);
        chk("par_err", AParErr, (x.vld != 0) && x.err);
        @(posedge AClkH);
        if (!AResetH && AClkHEn) begin
            e = '{vld: '0, data: '0, err: 1'b0};
            if (g >= 0) begin
                ptr = (g + 1) % NCh;
                ad = int'(AAddr[g*AW +: AW]);
                if (AWrEn[g]) begin
                    if (ad < MS)
                        for (int b = 0; b < BW; b++)
                            if (ABe[g*BW + b]) begin
                                mem[ad][b*8 +: 8] = AMosi[g*DW + b*8 +: 8];
                                if (b == 0) bad[ad] = 1'b0;
                            end
                end else begin
                    e.vld = NCh'(1) << g;
                    e.data = (ad < MS) ? mem[ad] : '0;
                    e.err = (ad < MS) && bad[ad];
                end
            end
            q.push_back(e);
            if (q.size() > RP + 1) void'(q.pop_front());
        end
        #1;
    endtask

    initial begin
        AResetH = 1'b1; AClkHEn = 1'b1; AReq = '1; AWrEn = '1;
        ABe = '0; AAddr = '0; AMosi = '0;
        repeat (3) tick();
        chk("rst_ack", obsAck, 0);
        AResetH = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ack_seq", obsAck, 4'b0001 << (i % 4));
        end
        AReq = 4'b0001;
        for (int i = 0; i < MS; i++) begin
            setCh(0, 1'b1, i, {$urandom, $urandom, $urandom, $urandom}, '1);
            tick();
        end
        setCh(2, 1'b1, 5, {16{8'hAA}}, '1); AReq = 4'b0100; tick();
        setCh(0, 1'b1, 5, 128'h11, 16'h0001); AReq = 4'b0001; tick();
        setCh(1, 1'b0, 5, '0, '0); AReq = 4'b0010; tick();
        AReq = '0; tick();
        chk("rmw_vld", obsVld, 4'b0010);
        chk("rmw_data", obsMiso, {{15{8'hAA}}, 8'h11});
        n = 0; AReq = 4'b1000;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) AReq = '0;
            setCh(3, 1'b0, i, '0, '0);
            tick();
            if (obsVld == 4'b1000) n++;
        end
        chk("b2b_count", n, 8);
        a = 10; n = 0; AReq = 4'b1000;
        for (int i = 0; i < 11; i++) begin
            AClkHEn = !(i >= 4 && i <= 6);
            setCh(3, 1'b0, a, '0, '0);
            tick();
            if (obsAck[3]) a++;
            if (!AClkHEn && (obsAck != 0 || obsVld != 0)) n++;
        end
        AClkHEn = 1'b1; AReq = '0; tick();
        chk("stall_quiet", n, 0);
        chk("stall_reads", a, 18);
        AReq = 4'b0010;
        setCh(1, 1'b1, 120, '1, '1); tick();
        setCh(1, 1'b0, 120, '0, '0); tick();
        setCh(1, 1'b0, 99, '0, '0); tick();
        chk("oor_vld", obsVld, 4'b0010);
        chk("oor_data", obsMiso, 0);
        AReq = '0; tick();
        chk("addr99", obsMiso, mem[99]);
        for (int i = 0; i < 400; i++) begin
            AClkHEn = ($urandom_range(9) != 0);
            AReq = NCh'($urandom);
            for (int c = 0; c < NCh; c++)
                setCh(c, 1'($urandom_range(1)), int'($urandom_range(127)),
                      {$urandom, $urandom, $urandom, $urandom}, BW'($urandom));
            tick();
        end
        AClkHEn = 1'b1; AReq = '0; tick(); tick();
`ifdef RAM_MP_ARB_PARITY_EN
        dut.memData[7] = dut.memData[7] ^ 128'h1;
        mem[7] = mem[7] ^ 128'h1;
        bad[7] = 1'b1;
        AReq = 4'b0001;
        setCh(0, 1'b0, 7, '0, '0); tick();
        setCh(0, 1'b0, 8, '0, '0); tick();
        chk("par_flip", obsPar, 1);
        AReq = '0; tick();
        chk("par_clean", obsPar, 0);
`endif
        AReq = 4'b0100; setCh(2, 1'b0, 3, '0, '0); tick();
        AReq = '0; AResetH = 1'b1; tick();
        chk("rst_drop", obsVld, 0);
        AResetH = 1'b0; tick();
        chk("post_rst_vld", obsVld, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
